// File: rtl/btn_evt_pkg.sv
// -----------------------------------------------------------------------------
// btn_evt_pkg
// Shared definitions for the button event controller:
//   - event codes presented on evt_code (PRESS, LONG, REPEAT, RELEASE)
//   - per-button FSM state encoding (IDLE, PRESSED, HELD)
//   - default hold / repeat periods in clock cycles (50 MHz system clock)
// -----------------------------------------------------------------------------
package btn_evt_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_LONG    = 2'd1,
        EVT_REPEAT  = 2'd2,
        EVT_RELEASE = 2'd3
    } evt_code_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_e;

    // 1 s and 200 ms at 50 MHz
    localparam int unsigned LONG_CYC_DEF = 32'd50_000_000;
    localparam int unsigned REP_CYC_DEF  = 32'd10_000_000;

endpackage

// File: rtl/btn_evt_fsm.sv
// -----------------------------------------------------------------------------
// btn_evt_fsm
// One button: edge detection, IDLE/PRESSED/HELD classifier with hold counter,
// and a one-deep pending event slot read by the arbiter.
// Ports:
//   ckht  in   system clock
//   rst_n in   asynchronous active-low reset
//   lvl   in   debounced button level, 1 = pressed
//   clr   in   slot accepted by the arbiter this cycle
//   pend  out  slot holds an event
//   code  out  event code held in the slot
//   ovf   out  one-cycle pulse: a full, unaccepted slot was overwritten
// -----------------------------------------------------------------------------
module btn_evt_fsm
    import btn_evt_pkg::*;
#(
    parameter int unsigned LONG_CYC = LONG_CYC_DEF,
    parameter int unsigned REP_CYC  = REP_CYC_DEF,
    parameter int unsigned CNT_W    = 26
) (
    input  logic       ckht,
    input  logic       rst_n,
    input  logic       lvl,
    input  logic       clr,
    output logic       pend,
    output logic [1:0] code,
    output logic       ovf
);

    // Thresholds are "count reaches N-1", so the counter never needs to
    // hold N and never wraps.
    localparam logic [CNT_W-1:0] LONG_TH = CNT_W'(LONG_CYC - 32'd1);
    localparam logic [CNT_W-1:0] REP_TH  = CNT_W'(REP_CYC - 32'd1);

    logic             lvl_q_r;
    btn_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pend_r;
    logic [1:0]       code_r;
    logic             ovf_r;

    logic             rise_s;
    logic             fall_s;
    logic             raise_s;
    evt_code_e        new_code_s;
    btn_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Next-state decode; a falling edge wins over LONG/REPEAT in the same cycle.
    always_comb begin
        rise_s      = lvl & ~lvl_q_r;
        fall_s      = ~lvl & lvl_q_r;
        raise_s     = 1'b0;
        new_code_s  = EVT_PRESS;
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    raise_s     = 1'b1;
                    new_code_s  = EVT_PRESS;
                    state_nxt_s = ST_PRESSED;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            end
            ST_PRESSED: begin
                if (fall_s) begin
                    raise_s     = 1'b1;
                    new_code_s  = EVT_RELEASE;
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if ((cnt_r == LONG_TH) && lvl) begin
                    raise_s     = 1'b1;
                    new_code_s  = EVT_LONG;
                    state_nxt_s = ST_HELD;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (fall_s) begin
                    raise_s     = 1'b1;
                    new_code_s  = EVT_RELEASE;
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == REP_TH) begin
                    raise_s     = 1'b1;
                    new_code_s  = EVT_REPEAT;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, edge register and pending slot update.
    always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q_r <= 1'b0;
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            pend_r  <= 1'b0;
            code_r  <= 2'd0;
            ovf_r   <= 1'b0;
        end else begin
            lvl_q_r <= lvl;
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (raise_s) begin
                // A slot being drained this cycle can refill without loss.
                pend_r <= 1'b1;
                code_r <= new_code_s;
                ovf_r  <= pend_r & ~clr;
            end else begin
                if (clr) begin
                    pend_r <= 1'b0;
                end else begin
                    pend_r <= pend_r;
                end
                code_r <= code_r;
                ovf_r  <= 1'b0;
            end
        end
    end

    assign pend = pend_r;
    assign code = code_r;
    assign ovf  = ovf_r;

endmodule

// File: rtl/btn_event_ctrl.sv
// -----------------------------------------------------------------------------
// btn_event_ctrl
// Classifies N_BTN debounced buttons into PRESS/LONG/REPEAT/RELEASE events and
// round-robin schedules pending events onto one valid/ready port.
// Ports:
//   ckht      in   system clock
//   rst_n     in   asynchronous active-low reset
//   btn_lvl   in   debounced levels, 1 = pressed
//   evt_valid out  event available (held until accepted)
//   evt_ready in   downstream accepts the event
//   evt_btn   out  index of the button that raised the event
//   evt_code  out  0 PRESS, 1 LONG, 2 REPEAT, 3 RELEASE
//   evt_ovf   out  one-cycle pulse when a pending event was overwritten
// -----------------------------------------------------------------------------
module btn_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int          N_BTN    = 4,
    parameter int unsigned LONG_CYC = LONG_CYC_DEF,
    parameter int unsigned REP_CYC  = REP_CYC_DEF,
    parameter int unsigned CNT_W    = 26
) (
    input  logic             ckht,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_lvl,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [2:0]       evt_btn,
    output logic [1:0]       evt_code,
    output logic             evt_ovf
);

    logic [N_BTN-1:0] pend_s;
    logic [N_BTN-1:0] clr_s;
    logic [N_BTN-1:0] ovf_s;
    logic [1:0]       code_s [N_BTN];

    // Per-button views widened to the 8-button maximum so a 3-bit index
    // always selects in range.
    logic [7:0]       pend_ext_s;
    logic [15:0]      code_ext_s;

    logic [3:0]       idx_s;
    logic             grant_found_s;
    logic [2:0]       grant_s;
    logic             load_s;
    logic [1:0]       sel_code_s;
    logic [3:0]       rr_nxt_s;

    logic [2:0]       rr_ptr_r;
    logic             evt_valid_r;
    logic [2:0]       evt_btn_r;
    logic [1:0]       evt_code_r;
    logic             evt_ovf_r;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_evt_fsm #(
            .LONG_CYC (LONG_CYC),
            .REP_CYC  (REP_CYC),
            .CNT_W    (CNT_W)
        ) u_fsm (
            .ckht  (ckht),
            .rst_n (rst_n),
            .lvl   (btn_lvl[g]),
            .clr   (clr_s[g]),
            .pend  (pend_s[g]),
            .code  (code_s[g]),
            .ovf   (ovf_s[g])
        );
    end

    // Round-robin grant from rr_ptr, load decision and slot-clear vector.
    always_comb begin
        pend_ext_s = 8'(pend_s);
        code_ext_s = {16{1'b0}};
        for (int i = 0; i < N_BTN; i++) begin
            code_ext_s[2*i +: 2] = code_s[i];
        end

        idx_s         = 4'd0;
        grant_found_s = 1'b0;
        grant_s       = 3'd0;
        for (int i = 0; i < N_BTN; i++) begin
            idx_s = {1'b0, rr_ptr_r} + 4'(i);
            if (idx_s >= 4'(N_BTN)) begin
                idx_s = idx_s - 4'(N_BTN);
            end else begin
                idx_s = idx_s;
            end
            if (!grant_found_s && pend_ext_s[idx_s[2:0]]) begin
                grant_found_s = 1'b1;
                grant_s       = idx_s[2:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end

        // Load when the output is empty or its event is taken this cycle.
        load_s     = (~evt_valid_r | evt_ready) & grant_found_s;
        sel_code_s = code_ext_s[{grant_s, 1'b0} +: 2];

        for (int i = 0; i < N_BTN; i++) begin
            clr_s[i] = load_s & (grant_s == 3'(i));
        end

        rr_nxt_s = {1'b0, grant_s} + 4'd1;
        if (rr_nxt_s == 4'(N_BTN)) begin
            rr_nxt_s = 4'd0;
        end else begin
            rr_nxt_s = rr_nxt_s;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r    <= 3'd0;
            evt_valid_r <= 1'b0;
            evt_btn_r   <= 3'd0;
            evt_code_r  <= 2'd0;
            evt_ovf_r   <= 1'b0;
        end else begin
            if (load_s) begin
                evt_valid_r <= 1'b1;
                evt_btn_r   <= grant_s;
                evt_code_r  <= sel_code_s;
                rr_ptr_r    <= rr_nxt_s[2:0];
            end else if (evt_ready) begin
                evt_valid_r <= 1'b0;
            end else begin
                evt_valid_r <= evt_valid_r;
            end
            evt_ovf_r <= |ovf_s;
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_btn   = evt_btn_r;
    assign evt_code  = evt_code_r;
    assign evt_ovf   = evt_ovf_r;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btn_event_ctrl
// Directed bench for btn_event_ctrl with N_BTN=4, LONG_CYC=20, REP_CYC=5.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_btn_event_ctrl;
    import btn_evt_pkg::*;

    localparam int          N_BTN    = 4;
    localparam int unsigned LONG_CYC = 32'd20;
    localparam int unsigned REP_CYC  = 32'd5;
    localparam int unsigned CNT_W    = 32'd8;

    logic       ckht = 1'b0;
    logic       rst_n;
    logic [3:0] btn_lvl;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_btn;
    logic [1:0] evt_code;
    logic       evt_ovf;

    int checks = 0;
    int errors = 0;

    // Captured events: tick index, code, button
    int ev_n;
    int ev_t    [16];
    int ev_code [16];
    int ev_btn  [16];

    always #5 ckht = ~ckht;

    btn_event_ctrl #(
        .N_BTN    (N_BTN),
        .LONG_CYC (LONG_CYC),
        .REP_CYC  (REP_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .ckht      (ckht),
        .rst_n     (rst_n),
        .btn_lvl   (btn_lvl),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_btn   (evt_btn),
        .evt_code  (evt_code),
        .evt_ovf   (evt_ovf)
    );

    task automatic tick;
        @(posedge ckht);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Run n_ticks cycles logging every valid event; drive drop_val after tick drop_at.
    task automatic capture(input int n_ticks, input int drop_at, input logic [3:0] drop_val);
        ev_n = 0;
        for (int i = 0; i < 16; i++) begin
            ev_t[i] = -1; ev_code[i] = -1; ev_btn[i] = -1;
        end
        for (int t = 1; t <= n_ticks; t++) begin
            tick;
            if (evt_valid === 1'b1 && ev_n < 16) begin
                ev_t[ev_n]    = t;
                ev_code[ev_n] = int'(evt_code);
                ev_btn[ev_n]  = int'(evt_btn);
                ev_n++;
            end
            if (t == drop_at) btn_lvl = drop_val;
        end
    endtask

    initial begin
        int extra;
        int ovf_n;
        int unstable;
        int ord[4];
        int exp2_t[7];
        int exp2_c[7];
        int exp5_t[3];
        int exp5_c[3];

        ord    = '{2, 3, 0, 1};
        exp2_t = '{2, 22, 27, 32, 37, 42, 44};
        exp2_c = '{0, 1, 2, 2, 2, 2, 3};
        exp5_t = '{2, 22, 27};
        exp5_c = '{0, 1, 3};

        rst_n     = 1'b0;
        btn_lvl   = 4'b0000;
        evt_ready = 1'b1;
        repeat (3) @(posedge ckht);
        #1;
        check("rst_valid", evt_valid, 0);
        check("rst_btn",   evt_btn,   0);
        check("rst_code",  evt_code,  0);
        check("rst_ovf",   evt_ovf,   0);
        rst_n = 1'b1;
        tick; tick;
        check("idle_valid", evt_valid, 0);

        // Button 1 pulse of 10 cycles: PRESS, RELEASE, no LONG
        btn_lvl = 4'b0010;
        tick;
        check("t1_lat1_valid", evt_valid, 0);
        tick;
        check("t1_press_valid", evt_valid, 1);
        check("t1_press_btn",   evt_btn,   1);
        check("t1_press_code",  evt_code,  EVT_PRESS);
        extra = 0;
        repeat (8) begin
            tick;
            if (evt_valid !== 1'b0) extra++;
        end
        check("t1_no_long", extra, 0);
        btn_lvl = 4'b0000;
        tick;
        check("t1_rel_lat1", evt_valid, 0);
        tick;
        check("t1_rel_valid", evt_valid, 1);
        check("t1_rel_btn",   evt_btn,   1);
        check("t1_rel_code",  evt_code,  EVT_RELEASE);
        tick;
        check("t1_drain", evt_valid, 0);

        // All buttons rise together; pointer now 2 after button 1's events
        btn_lvl = 4'b1111;
        tick;
        check("t3_lat1", evt_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("t3_press_valid", evt_valid, 1);
            check("t3_press_btn",   evt_btn,   ord[i]);
            check("t3_press_code",  evt_code,  EVT_PRESS);
        end
        btn_lvl = 4'b0000;
        tick;
        check("t3_gap", evt_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("t3_rel_valid", evt_valid, 1);
            check("t3_rel_btn",   evt_btn,   ord[i]);
            check("t3_rel_code",  evt_code,  EVT_RELEASE);
        end
        tick;
        check("t3_drain", evt_valid, 0);

        // Button 2 held: PRESS, LONG +20, four REPEATs every 5, RELEASE
        btn_lvl = 4'b0100;
        capture(50, 42, 4'b0000);
        check("t2_count", ev_n, 7);
        for (int i = 0; i < 7; i++) begin
            check("t2_time", ev_t[i],    exp2_t[i]);
            check("t2_code", ev_code[i], exp2_c[i]);
            check("t2_btn",  ev_btn[i],  2);
        end

        // Stalled output: PRESS held, LONG in slot overwritten by RELEASE
        evt_ready = 1'b0;
        btn_lvl   = 4'b0001;
        ovf_n     = 0;
        unstable  = 0;
        for (int t = 1; t <= 30; t++) begin
            tick;
            if (evt_ovf === 1'b1) ovf_n++;
            if (t >= 2) begin
                if (!(evt_valid === 1'b1 && evt_btn === 3'd0 && evt_code === 2'd0)) unstable++;
            end
            if (t == 22) btn_lvl = 4'b0000;
            if (t == 30) evt_ready = 1'b1;
        end
        check("t4_ovf_pulses", ovf_n, 1);
        check("t4_stable",     unstable, 0);
        tick;
        check("t4_latest_valid", evt_valid, 1);
        check("t4_latest_btn",   evt_btn,   0);
        check("t4_latest_code",  evt_code,  EVT_RELEASE);
        tick;
        check("t4_drain", evt_valid, 0);

        // Button 3 released exactly at the REPEAT threshold: RELEASE only
        btn_lvl = 4'b1000;
        capture(35, 25, 4'b0000);
        check("t5_count", ev_n, 3);
        for (int i = 0; i < 3; i++) begin
            check("t5_time", ev_t[i],    exp5_t[i]);
            check("t5_code", ev_code[i], exp5_c[i]);
            check("t5_btn",  ev_btn[i],  3);
        end

        // Reset while an event is valid clears the output without a clock edge
        btn_lvl = 4'b0100;
        tick; tick;
        check("t6_pre_valid", evt_valid, 1);
        check("t6_pre_btn",   evt_btn,   2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", evt_valid, 0);
        check("t6_async_btn",   evt_btn,   0);
        check("t6_async_code",  evt_code,  0);
        tick; tick;
        rst_n = 1'b1;
        tick;
        check("t6_lat1", evt_valid, 0);
        tick;
        check("t6_press_valid", evt_valid, 1);
        check("t6_press_btn",   evt_btn,   2);
        check("t6_press_code",  evt_code,  EVT_PRESS);
        btn_lvl = 4'b0000;
        repeat (4) tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
